fir_sched_ctrl: RTL and testbench

Time-multiplexing controller for the 6-tap FIR dataflow graph: computes y = Σ in[i]·coef[i], i=0..5, using one shared multiplier and one shared adder instead of six and five dedicated units. It accepts a sample set, issues the six multiplications and five additions on a fixed 7-step schedule, and returns the sum over a valid/ready handshake. Per-operation accurate/approximate selection is held in a mode register. The block sits between the sample source and the shared `mul_x`/`add_x` arithmetic units.

---
 rtl/fir_sched_pkg.sv | 20 ++
 rtl/fir_sched_ctrl_if.sv | 42 ++++
 rtl/fir_sched_cfg.sv | 41 ++++
 rtl/fir_sched_ctrl.sv | 154 +++++++++++++++
 tb/tb_fir_sched_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared constants and types for the time-multiplexed 6-tap FIR controller
package fir_sched_pkg;

  localparam int TAPS      = 6;
  localparam int NADD      = 5;
  localparam int STEP_W    = 3;
  localparam int LAST_STEP = NADD + 1;
  localparam int MASK_W    = TAPS + NADD;

  // Mode mask layout: bits [5:0] select approximate multiply per tap, bits [10:6] approximate add per step 2..6.
  localparam int MUL_BIT0 = 0;
  localparam int ADD_BIT0 = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_sched_ctrl_if.sv
// rtl/fir_sched_ctrl_if.sv - sample/result handshake, config port and shared arithmetic unit bus
interface fir_sched_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int OUT_W  = PROD_W + 3;

  logic                  in_valid;
  logic                  in_ready;
  logic [6*DATA_W-1:0]   in_data;
  logic                  cfg_we;
  logic [2:0]            cfg_addr;
  logic [COEF_W-1:0]     cfg_data;
  logic [DATA_W-1:0]     mul_a;
  logic [COEF_W-1:0]     mul_b;
  logic                  mul_en;
  logic                  mul_approx;
  logic [PROD_W-1:0]     mul_y;
  logic [OUT_W-1:0]      add_a;
  logic [OUT_W-1:0]      add_b;
  logic                  add_en;
  logic                  add_approx;
  logic [OUT_W-1:0]      add_y;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic                  busy;

  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_data, mul_y, add_y, out_ready,
    input  in_ready, mul_a, mul_b, mul_en, mul_approx, add_a, add_b, add_en, add_approx,
           out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_addr, cfg_data, mul_y, add_y, out_ready,
    output in_ready, mul_a, mul_b, mul_en, mul_approx, add_a, add_b, add_en, add_approx,
           out_valid, out_data, busy
  );

endinterface

// File: rtl/fir_sched_cfg.sv
// rtl/fir_sched_cfg.sv - coefficient and mode-mask shadow registers with write decode
module fir_sched_cfg
  import fir_sched_pkg::*;
#(
  parameter int COEF_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic [2:0]             addr_i,
  input  logic [COEF_W-1:0]      data_i,
  output logic [TAPS*COEF_W-1:0] coef_o,
  output logic [MASK_W-1:0]      mask_o
);

  logic [COEF_W-1:0] coef_q [TAPS];
  logic [MASK_W-1:0] mask_q;

  // Address 6 falls through both branches and is deliberately a no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
      mask_q <= '0;
    end else if (we_i) begin
      if (addr_i < 3'(TAPS)) begin
        coef_q[addr_i] <= data_i;
      end else if (addr_i == 3'd7) begin
        mask_q <= data_i[MASK_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_coef
    assign coef_o[g*COEF_W +: COEF_W] = coef_q[g];
  end

  assign mask_o = mask_q;

endmodule

// File: rtl/fir_sched_ctrl.sv
// rtl/fir_sched_ctrl.sv - schedules six multiplies and five adds of a 6-tap FIR onto one shared
// multiplier and one shared adder over a fixed 7-step sequence
module fir_sched_ctrl
  import fir_sched_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_sched_ctrl_if.slave bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int OUT_W  = PROD_W + 3;

  logic [TAPS*COEF_W-1:0] cfg_coef;
  logic [MASK_W-1:0]      cfg_mask;

  fir_sched_cfg #(
    .COEF_W (COEF_W)
  ) u_cfg (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (bus.cfg_we),
    .addr_i (bus.cfg_addr),
    .data_i (bus.cfg_data),
    .coef_o (cfg_coef),
    .mask_o (cfg_mask)
  );

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [DATA_W-1:0]  smp_q  [TAPS];
  logic [COEF_W-1:0]  coef_q [TAPS];
  logic [MASK_W-1:0]  mask_q;
  logic [PROD_W-1:0]  p_q;
  logic [OUT_W-1:0]   acc_q;
  logic [OUT_W-1:0]   out_data_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               accept;
  logic               mul_issue;
  logic               add_issue;
  logic               acc_load;
  logic               last_step;
  logic [STEP_W-1:0]  tap_idx;
  logic [3:0]         mul_bit;
  logic [3:0]         add_bit;
  logic [OUT_W-1:0]   p_ext;

  assign accept    = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign mul_issue = (state_q == RUN) && (step_q <= STEP_W'(TAPS - 1));
  assign add_issue = (state_q == RUN) && (step_q >= STEP_W'(2));
  assign acc_load  = (state_q == RUN) && (step_q == STEP_W'(1));
  assign last_step = (state_q == RUN) && (step_q == STEP_W'(LAST_STEP));

  // Index helpers are forced to a safe in-range value whenever the matching strobe is low.
  assign tap_idx = mul_issue ? step_q : '0;
  assign mul_bit = 4'(MUL_BIT0) + 4'(tap_idx);
  assign add_bit = add_issue ? (4'(ADD_BIT0) + 4'(step_q) - 4'd2) : 4'(ADD_BIT0);
  assign p_ext   = {{(OUT_W - PROD_W){p_q[PROD_W-1]}}, p_q};

  assign bus.mul_en     = mul_issue;
  assign bus.mul_a      = mul_issue ? smp_q[tap_idx]  : '0;
  assign bus.mul_b      = mul_issue ? coef_q[tap_idx] : '0;
  assign bus.mul_approx = mul_issue && mask_q[mul_bit];

  assign bus.add_en     = add_issue;
  assign bus.add_a      = add_issue ? acc_q : '0;
  assign bus.add_b      = add_issue ? p_ext : '0;
  assign bus.add_approx = add_issue && mask_q[add_bit];

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = busy_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          step_d  = '0;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      p_q         <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      for (int i = 0; i < TAPS; i++) begin
        smp_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);

      if (accept) begin
        for (int i = 0; i < TAPS; i++) begin
          smp_q[i]  <= bus.in_data[i*DATA_W +: DATA_W];
          coef_q[i] <= cfg_coef[i*COEF_W +: COEF_W];
        end
        mask_q <= cfg_mask;
      end

      if (mul_issue) begin
        p_q <= bus.mul_y;
      end

      if (acc_load) begin
        acc_q <= p_ext;
      end else if (add_issue) begin
        acc_q <= bus.add_y;
      end

      if (last_step) begin
        out_data_q <= bus.add_y;
      end
    end
  end

endmodule

// File: tb/tb_fir_sched_ctrl.sv
// tb/tb_fir_sched_ctrl.sv - scoreboard bench for fir_sched_ctrl with behavioural shared mul/add units
module tb_fir_sched_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fir_sched_ctrl_if #(.DATA_W(16), .COEF_W(16)) bus ();

  fir_sched_ctrl #(.DATA_W(16), .COEF_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Exact shared arithmetic units.
  assign bus.mul_y = $signed(bus.mul_a) * $signed(bus.mul_b);
  assign bus.add_y = bus.add_a + bus.add_b;

  int                 vec_cnt  = 0;
  int                 miss_cnt = 0;
  longint             exp_q[$];
  logic signed [15:0] tb_coef [6];
  logic [10:0]        tb_mask;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [95:0] pack_ramp(input int base, input int stride);
    logic [95:0] d;
    for (int i = 0; i < 6; i++) d[i*16 +: 16] = 16'(base + i * stride);
    return d;
  endfunction

  task automatic write_cfg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    if (a < 3'd6) tb_coef[a] = d;
    else if (a == 3'd7) tb_mask = d[10:0];
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // Runs one transaction starting at a negedge and returns at the negedge after the result handshake.
  task automatic run_txn(input string nm, input logic [95:0] d, input int hold, input int wr_step,
                         input logic [15:0] wr_data, output int waited,
                         output logic [6:0] mul_ap, output logic [6:0] add_ap);
    int                 cnt, mul_cnt, add_cnt, both_cnt, sched_err, bp_err;
    logic signed [15:0] snap [6];
    logic [10:0]        m;
    longint             pr [6];
    longint             part, tot;
    logic [34:0]        exp35, held;
    cnt = 0; mul_cnt = 0; add_cnt = 0; both_cnt = 0; sched_err = 0; bp_err = 0;
    mul_ap = '0; add_ap = '0; waited = 0; tot = 0;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL %s accept: in_ready=%b required 1", nm, bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 6; i++) begin
      snap[i] = tb_coef[i];
      pr[i]   = longint'($signed(d[i*16 +: 16])) * longint'(snap[i]);
      tot    += pr[i];
    end
    m = tb_mask;
    exp_q.push_back(tot);
    @(posedge clk);
    while (cnt < 20) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.cfg_we   = (cnt == wr_step);
      bus.cfg_addr = 3'd0;
      bus.cfg_data = wr_data;
      if (cnt == wr_step) tb_coef[0] = wr_data;
      if (bus.out_valid === 1'b1) break;
      if (bus.mul_en === 1'b1) mul_cnt++;
      if (bus.add_en === 1'b1) add_cnt++;
      if (bus.mul_en === 1'b1 && bus.add_en === 1'b1) both_cnt++;
      if (cnt < 7) begin
        mul_ap[cnt] = bus.mul_approx;
        add_ap[cnt] = bus.add_approx;
      end
      if (cnt <= 5) begin
        if (bus.mul_en !== 1'b1 || bus.mul_a !== d[cnt*16 +: 16] || bus.mul_b !== snap[cnt] ||
            bus.mul_approx !== m[cnt]) sched_err++;
      end else if (bus.mul_en !== 1'b0 || bus.mul_a !== '0 || bus.mul_b !== '0 || bus.mul_approx !== 1'b0) begin
        sched_err++;
      end
      if (cnt >= 2 && cnt <= 6) begin
        part = 0;
        for (int k = 0; k < cnt - 1; k++) part += pr[k];
        if (bus.add_en !== 1'b1 || bus.add_a !== 35'(part) || bus.add_b !== 35'(pr[cnt-1]) ||
            bus.add_approx !== m[6 + cnt - 2]) sched_err++;
      end else if (bus.add_en !== 1'b0 || bus.add_a !== '0 || bus.add_b !== '0 || bus.add_approx !== 1'b0) begin
        sched_err++;
      end
      cnt++;
    end
    bus.cfg_we = 1'b0;

    vec_cnt++;
    if (cnt != 7) begin miss_cnt++; $display("FAIL %s latency: got %0d cycles, expected 7", nm, cnt); end
    vec_cnt++;
    if (mul_cnt != 6) begin miss_cnt++; $display("FAIL %s mul_en cycles: got %0d, expected 6", nm, mul_cnt); end
    vec_cnt++;
    if (add_cnt != 5) begin miss_cnt++; $display("FAIL %s add_en cycles: got %0d, expected 5", nm, add_cnt); end
    vec_cnt++;
    if (both_cnt != 4) begin miss_cnt++; $display("FAIL %s overlap cycles: got %0d, expected 4", nm, both_cnt); end
    vec_cnt++;
    if (sched_err != 0) begin miss_cnt++; $display("FAIL %s operand schedule: %0d bad steps, expected 0", nm, sched_err); end

    exp35 = 35'(exp_q.pop_front());
    vec_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp35) begin
      miss_cnt++;
      $display("FAIL %s out_data: got %0d (valid=%b), expected %0d", nm, $signed(bus.out_data), bus.out_valid,
               $signed(exp35));
    end

    held = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = ~d;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== held) bp_err++;
    end
    if (hold > 0) begin
      vec_cnt++;
      if (bp_err != 0) begin miss_cnt++; $display("FAIL %s backpressure hold: %0d bad cycles, expected 0", nm, bp_err); end
    end

    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    vec_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miss_cnt++;
      $display("FAIL %s release: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", nm, bus.in_ready,
               bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mul_en !== 1'b0 ||
        bus.add_en !== 1'b0 || bus.out_data !== '0 || bus.add_a !== '0 || bus.mul_a !== '0) begin
      miss_cnt++;
      $display("FAIL reset values: in_ready=%b out_valid=%b busy=%b mul_en=%b add_en=%b out_data=%0d, expected all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.mul_en, bus.add_en, bus.out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset release: in_ready=%b busy=%b, expected 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_basic;
    int w; logic [6:0] ma, aa;
    for (int i = 0; i < 6; i++) write_cfg(3'(i), 16'(i + 1));
    write_cfg(3'd7, 16'h0000);
    write_cfg(3'd6, 16'h7FFF);
    run_txn("basic", pack_ramp(1, 1), 0, -1, 16'h0, w, ma, aa);
    run_txn("basic_neg", pack_ramp(-3, 2), 0, -1, 16'h0, w, ma, aa);
  endtask

  task automatic test_extremes;
    int w; logic [6:0] ma, aa;
    logic [95:0] d;
    write_cfg(3'd0, 16'hFFFF); write_cfg(3'd1, 16'd2); write_cfg(3'd2, 16'hFFFD);
    write_cfg(3'd3, 16'd4);    write_cfg(3'd4, 16'hFFFB); write_cfg(3'd5, 16'd6);
    d = {6{16'h7FFF}};
    run_txn("max_pos", d, 0, -1, 16'h0, w, ma, aa);
    for (int i = 0; i < 6; i++) write_cfg(3'(i), 16'h8000);
    d = {6{16'h8000}};
    run_txn("max_neg", d, 0, -1, 16'h0, w, ma, aa);
  endtask

  task automatic test_backpressure;
    int w; logic [6:0] ma, aa;
    for (int i = 0; i < 6; i++) write_cfg(3'(i), 16'(i + 1));
    run_txn("bp_hold", pack_ramp(1, 1), 10, -1, 16'h0, w, ma, aa);
    run_txn("bp_next", pack_ramp(7, 3), 0, -1, 16'h0, w, ma, aa);
    vec_cnt++;
    if (w != 0) begin miss_cnt++; $display("FAIL bp_next accept wait: got %0d cycles, expected 0", w); end
  endtask

  task automatic test_back_to_back;
    int w; logic [6:0] ma, aa;
    run_txn("b2b_a", pack_ramp(100, -37), 0, -1, 16'h0, w, ma, aa);
    run_txn("b2b_b", pack_ramp(-500, 211), 0, -1, 16'h0, w, ma, aa);
    vec_cnt++;
    if (w != 0) begin miss_cnt++; $display("FAIL b2b initiation: waited %0d extra cycles, expected 0", w); end
  endtask

  task automatic test_snapshot;
    int w; logic [6:0] ma, aa;
    write_cfg(3'd0, 16'd1);
    run_txn("snap_old", pack_ramp(1, 1), 0, 3, 16'd100, w, ma, aa);
    run_txn("snap_new", pack_ramp(1, 1), 0, -1, 16'h0, w, ma, aa);
  endtask

  task automatic test_mask;
    int w; logic [6:0] ma, aa;
    write_cfg(3'd7, 16'h05A5);
    run_txn("mask", pack_ramp(2, 5), 0, -1, 16'h0, w, ma, aa);
    vec_cnt++;
    if (ma !== 7'b0100101) begin miss_cnt++; $display("FAIL mask mul_approx steps: got %b, expected 0100101", ma); end
    vec_cnt++;
    if (aa !== 7'b1011000) begin miss_cnt++; $display("FAIL mask add_approx steps: got %b, expected 1011000", aa); end
    write_cfg(3'd7, 16'h0000);
  endtask

  task automatic test_reset_abort;
    int w, waited, bad; logic [6:0] ma, aa;
    for (int i = 0; i < 6; i++) write_cfg(3'(i), 16'(3 * i + 2));
    bus.in_data  = pack_ramp(5, 9);
    bus.in_valid = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.mul_en !== 1'b0 || bus.add_en !== 1'b0 || bus.mul_a !== '0 || bus.mul_b !== '0 ||
        bus.add_a !== '0 || bus.add_b !== '0) begin
      miss_cnt++;
      $display("FAIL abort strobes: mul_en=%b add_en=%b, expected 0 0 with zero operands", bus.mul_en, bus.add_en);
    end
    vec_cnt++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      miss_cnt++;
      $display("FAIL abort flags: busy=%b in_ready=%b out_valid=%b out_data=%0d, expected 0 0 0 0",
               bus.busy, bus.in_ready, bus.out_valid, bus.out_data);
    end
    for (int i = 0; i < 6; i++) tb_coef[i] = '0;
    tb_mask = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin miss_cnt++; $display("FAIL abort partial result: out_valid seen %0d cycles, expected 0", bad); end
    run_txn("post_reset_zero", pack_ramp(5, 9), 0, -1, 16'h0, w, ma, aa);
    for (int i = 0; i < 6; i++) write_cfg(3'(i), 16'(7 - i));
    run_txn("post_reset_run", pack_ramp(-20, 13), 0, -1, 16'h0, w, ma, aa);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tb_coef[i] = '0;
    tb_mask = '0;
    test_reset;
    test_basic;
    test_extremes;
    test_backpressure;
    test_back_to_back;
    test_snapshot;
    test_mask;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
